// File: rtl/seq_restoring_divider.sv
`timescale 1ns/1ps
// seq_restoring_divider
// Iterative radix-2 restoring divider for unsigned operands.
// One trial subtraction per cycle, MSB first, with a start/busy/done handshake.
// Each operation takes W iteration cycles after the accepting edge.
// done, quotient, remainder and div_by_zero are all loaded on the edge that
// performs the last iteration. That edge moves the FSM into FIN, and FIN is
// the one cycle in which done=1 and busy=0.
// A start seen during FIN is accepted, so results stream back-to-back every
// W+1 cycles.
module seq_restoring_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  // Partial remainder. After every restoring step it is strictly below the
  // divisor, so its top bit (bit W of the W+1-bit working value) is always
  // zero between cycles. Only the low W bits are kept; the full W+1-bit width
  // exists inside the step function.
  logic [W-1:0]    p_r;
  logic [W-1:0]    q_r;
  logic [W-1:0]    d_r;
  logic            accept_s;
  logic            last_iter_s;
  logic [2*W-1:0]  step_s;

  // One restoring iteration: shift in the next dividend bit, trial-subtract
  // the divisor, and keep the difference only when it did not borrow.
  // Returns {next partial remainder, next quotient shift register}.
  function automatic logic [2*W-1:0] restore_step(
    input logic [W-1:0] p,
    input logic [W-1:0] q,
    input logic [W-1:0] d
  );
    logic [W:0] p_shift;
    logic [W:0] trial;
    p_shift = {1'b0, p[W-1:0], q[W-1]};
    trial   = p_shift - {1'b0, d};
    if (trial[W] == 1'b0) begin
      restore_step = {trial[W-1:0], q[W-2:0], 1'b1};
    end else begin
      restore_step = {p_shift[W-1:0], q[W-2:0], 1'b0};
    end
  endfunction

  assign step_s      = restore_step(p_r, q_r, d_r);
  assign last_iter_s = (state_r == RUN) && (cnt_r == LAST_ITER);

  // Next-state logic and the accept decision (start is honoured only while not busy).
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_iter_s) begin
          state_s = FIN;
        end else begin
          state_s = RUN;
        end
      end
      FIN: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s  = IDLE;
        accept_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, shift registers and the iteration counter (held at its last value, no wrap).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r   <= {W{1'b0}};
      q_r   <= {W{1'b0}};
      d_r   <= {W{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      p_r   <= {W{1'b0}};
      q_r   <= dividend;
      d_r   <= divisor;
      cnt_r <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      p_r <= step_s[2*W-1:W];
      q_r <= step_s[W-1:0];
      if (last_iter_s) begin
        cnt_r <= cnt_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Registered handshake and result outputs; results change only on the final iteration edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {W{1'b0}};
      remainder   <= {W{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_s == RUN);
      done <= (state_s == FIN);
      if (last_iter_s) begin
        quotient    <= step_s[W-1:0];
        remainder   <= step_s[2*W-1:W];
        div_by_zero <= (d_r == {W{1'b0}});
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
`timescale 1ns/1ps
// Self-checking bench for seq_restoring_divider (W=8): directed table,
// multi-cycle corner sequences and a randomized sweep against an
// arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[8];

  seq_restoring_divider #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned division; a zero divisor gives all ones and the dividend back.
  task automatic ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endtask

  // Raise start with operands, drop it after the accepting edge, then wait
  // (bounded) for done. lat counts clock edges from raising start to seeing done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int q, output int r, output int z, output int lat);
    bit finished;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    lat      = 0;
    finished = 1'b0;
    while (!finished) begin
      @(posedge clk);
      #1;
      if (lat == 0) begin
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      lat++;
      if (done) begin
        finished = 1'b1;
      end else if (lat >= 40) begin
        chk("done_timeout", lat, 9);
        finished = 1'b1;
      end else begin
        chk("busy_while_running", int'(busy), 1);
      end
    end
    chk("busy_in_done_cycle", int'(busy), 0);
    q = int'(quotient);
    r = int'(remainder);
    z = int'(div_by_zero);
  endtask

  initial begin
    int q, r, z, lat, eq, er, ez, cnt, chg;
    int a, b;
    bit finished;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    #20 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);

    // Directed table; consecutive entries also start in the previous done cycle.
    tbl[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  z: 1'b0};
    tbl[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0};
    tbl[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0};
    tbl[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0};
    tbl[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  z: 1'b0};
    tbl[5] = '{a: 8'd77,  b: 8'd0,   q: 8'd255, r: 8'd77, z: 1'b1};
    tbl[6] = '{a: 8'd10,  b: 8'd3,   q: 8'd3,   r: 8'd1,  z: 1'b0};
    tbl[7] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  z: 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, q, r, z, lat);
      chk("table_latency", lat, 9);
      chk("table_quotient", q, int'(tbl[i].q));
      chk("table_remainder", r, int'(tbl[i].r));
      chk("table_dbz", z, int'(tbl[i].z));
    end

    // Back-to-back: 81/4 raised in the done cycle of the previous entry.
    run_op(8'd81, 8'd4, q, r, z, lat);
    chk("b2b_latency", lat, 9);
    chk("b2b_quotient", q, 20);
    chk("b2b_remainder", r, 1);

    // Mid-run interference: 50/5 pulsed in the third busy cycle must be ignored.
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd9;
    lat      = 0;
    finished = 1'b0;
    while (!finished) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
      end
      if (lat == 3) begin
        chk("interfere_busy", int'(busy), 1);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (lat == 4) begin
        start = 1'b0;
      end
      if (done || lat >= 40) begin
        finished = 1'b1;
      end
    end
    chk("interfere_latency", lat, 9);
    chk("interfere_quotient", int'(quotient), 11);
    chk("interfere_remainder", int'(remainder), 1);
    cnt = 0;
    chg = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
      if (quotient != 8'd11 || remainder != 8'd1 || div_by_zero != 1'b0) chg++;
    end
    chk("interfere_extra_done", cnt, 0);
    chk("interfere_hold", chg, 0);

    // Randomized sweep against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = (i % 4 == 0) ? $urandom_range(1, 15) : $urandom_range(0, 255);
      ref_div(a, b, eq, er, ez);
      run_op(W'(a), W'(b), q, r, z, lat);
      chk("rand_latency", lat, 9);
      chk("rand_quotient", q, eq);
      chk("rand_remainder", r, er);
      chk("rand_dbz", z, ez);
      if (b != 0) begin
        chk("rand_identity", q * b + r, a);
        chk("rand_rem_below_div", int'(r < b), 1);
      end
    end

    // Reset mid-operation, asserted off the clock edge in busy cycle 4.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    run_op(8'd9, 8'd2, q, r, z, lat);
    chk("postrst_latency", lat, 9);
    chk("postrst_quotient", q, 4);
    chk("postrst_remainder", r, 1);
    chk("postrst_dbz", z, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
